// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequence-detector step scheduler.
package seq_ctrl_pkg;

  // Scheduler states: waiting, free-running on the period timer, single step.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  // Shortest legal step period; keeps step_en pulses at least two cycles apart.
  localparam int unsigned DIV_MIN = 2;

  // Step period after reset: 20 M cycles of Sys_Clk0.
  localparam int unsigned DIV_DEFAULT_CYC = 20000000;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser for a raw switch/button, with an optional debouncer.
// Build option SEQ_STEP_DEBOUNCE_EN: when defined, the synchronised level only
// propagates after DBNC_CYC consecutive identical samples.
module sync_debounce #(
  parameter int unsigned DBNC_CYC = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  // Metastability guard: two back-to-back flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

`ifdef SEQ_STEP_DEBOUNCE_EN
  localparam int unsigned CW = (DBNC_CYC > 1) ? $clog2(DBNC_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  // Count consecutive samples that disagree with the output; flip on the last one.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (s2_q != out_q) begin
      if (cnt_q == CW'(DBNC_CYC - 1)) begin
        out_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce counter and filtered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign q_o = out_q;
`else
  // Debounce length only matters when the filter is built in.
  if (DBNC_CYC == 0) begin : g_dbnc_unused
  end

  assign q_o = s2_q;
`endif

endmodule

// File: rtl/seq_step_ctrl.sv
// Step scheduler for the 0011 sequence detector: free-run or single-step with a
// programmable period, input synchronisation, detection counting and blink LED.
// Build option SEQ_STEP_DEBOUNCE_EN adds debouncing on run_sw and step_btn.
//
// state | meaning
// IDLE  | no stepping; waits for run switch or a button press
// RUN   | free-running; one step every period_q cycles
// STEP  | issues one step, then back to IDLE
module seq_step_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W       = 27,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_CYC,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DBNC_CYC    = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             x_in,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  input  logic             det_n,
  output logic             step_en,
  output logic             x_out,
  output logic [CNT_W-1:0] det_cnt,
  output logic             det_pulse,
  output logic             blinkled
);

  logic run_s, btn_s, btn_rise;
  logic x_s1_q, x_s2_q, btn_prev_q;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             step_en_q, step_en_d;
  logic             x_out_q, x_out_d;
  logic             blink_q, blink_d;
  logic             samp_q, samp_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic             det_pulse_q, det_pulse_d;
  logic             issue;

  sync_debounce #(.DBNC_CYC(DBNC_CYC)) u_run_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (run_sw),
    .q_o   (run_s)
  );

  sync_debounce #(.DBNC_CYC(DBNC_CYC)) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (step_btn),
    .q_o   (btn_s)
  );

  // Data bit synchroniser (never debounced) and button edge history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_s1_q     <= 1'b0;
      x_s2_q     <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      x_s1_q     <= x_in;
      x_s2_q     <= x_s1_q;
      btn_prev_q <= btn_s;
    end
  end

  assign btn_rise = btn_s & ~btn_prev_q;

  // Next state, period timer, step issue and detection bookkeeping.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    period_d  = period_q;
    issue     = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (run_s) begin
          state_d = RUN;
        end else if (btn_rise) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (!run_s) begin
          state_d   = IDLE;
          div_cnt_d = '0;
        end else if (div_load) begin
          div_cnt_d = '0;
        end else if (div_cnt_q == period_q - DIV_W'(1)) begin
          issue     = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      STEP: begin
        state_d   = IDLE;
        div_cnt_d = '0;
        issue     = ~div_load;
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = '0;
      end
    endcase

    // A period write restarts the timer; the new period counts from the next cycle.
    if (div_load) begin
      period_d  = (div_val < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_val;
      div_cnt_d = '0;
    end

    step_en_d = issue;
    x_out_d   = issue ? x_s2_q : x_out_q;
    blink_d   = blink_q ^ issue;

    // det_n is meaningful one cycle after the detector consumed the step.
    samp_d      = step_en_q;
    det_pulse_d = samp_q & ~det_n;
    det_cnt_d   = det_cnt_q;
    if (det_pulse_d && (det_cnt_q != '1)) begin
      det_cnt_d = det_cnt_q + CNT_W'(1);
    end
  end

  // State register and all output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      period_q    <= DIV_W'(DIV_DEFAULT);
      step_en_q   <= 1'b0;
      x_out_q     <= 1'b0;
      blink_q     <= 1'b0;
      samp_q      <= 1'b0;
      det_cnt_q   <= '0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      period_q    <= period_d;
      step_en_q   <= step_en_d;
      x_out_q     <= x_out_d;
      blink_q     <= blink_d;
      samp_q      <= samp_d;
      det_cnt_q   <= det_cnt_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  assign step_en   = step_en_q;
  assign x_out     = x_out_q;
  assign det_cnt   = det_cnt_q;
  assign det_pulse = det_pulse_q;
  assign blinkled  = blink_q;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Bench for seq_step_ctrl: directed phases with random data, checked every cycle
// against a schedule-based reference model (absolute step due times, input history).
module tb_seq_step_ctrl;

  localparam int DIV_W   = 27;
  localparam int DIV_DEF = 4;
  localparam int CNT_W   = 8;
  localparam int DBNC    = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int MAXC    = 20000;
`ifdef SEQ_STEP_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DBNC;
  localparam int HOLD   = DBNC + 4;
`else
  localparam int SW_LAT = 2;
  localparam int HOLD   = 5;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic             clk = 1'b0;
  logic             rst_n, run_sw, step_btn, x_in, div_load, det_n;
  logic [DIV_W-1:0] div_val;
  logic             step_en, x_out, det_pulse, blinkled;
  logic [CNT_W-1:0] det_cnt;

  always #5 clk = ~clk;

  seq_step_ctrl #(
    .DIV_W(DIV_W), .DIV_DEFAULT(DIV_DEF), .CNT_W(CNT_W), .DBNC_CYC(DBNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn), .x_in(x_in),
    .div_load(div_load), .div_val(div_val), .det_n(det_n), .step_en(step_en),
    .x_out(x_out), .det_cnt(det_cnt), .det_pulse(det_pulse), .blinkled(blinkled)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit run_h [MAXC];
  bit btn_h [MAXC];
  bit x_h   [MAXC];
  int cyc = 0;
  int rst_edge = 0;
  int m_mode = M_IDLE;
  int m_period = DIV_DEF;
  int m_due = 0;
  int m_cnt = 0;
  bit m_step = 0, m_x = 0, m_pulse = 0, m_blink = 0;
  int pend[$];
  bit prev_step = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // raw input value captured at edge k, as the synchroniser chain would hold it
  function automatic bit hv(input int which, input int k);
    if (k < rst_edge + 1) return 1'b0;
    case (which)
      0:       return run_h[k];
      1:       return btn_h[k];
      default: return x_h[k];
    endcase
  endfunction

  // level of a control input as seen by the scheduler at edge n
  function automatic bit seen(input int which, input int n);
`ifdef SEQ_STEP_DEBOUNCE_EN
    bit ok;
    for (int k = n - 3; k >= rst_edge + 1; k--) begin
      ok = 1'b1;
      for (int i = 1; i < DBNC; i++) if (hv(which, k - i) != hv(which, k)) ok = 1'b0;
      if (ok) return hv(which, k);
    end
    return 1'b0;
`else
    return hv(which, n - 2);
`endif
  endfunction

  // advance the model over the coming edge using the inputs as they stand now
  task automatic model_step();
    int  n;
    bit  rs, bs, bp, xs, fire, pulse;
    cyc++;
    n = cyc;
    run_h[n] = run_sw;
    btn_h[n] = step_btn;
    x_h[n]   = x_in;
    if (!rst_n) begin
      rst_edge = n;
      m_mode = M_IDLE; m_period = DIV_DEF; m_due = 0; m_cnt = 0;
      m_step = 0; m_x = 0; m_pulse = 0; m_blink = 0;
      pend.delete();
    end else begin
      rs = seen(0, n);
      bs = seen(1, n);
      bp = seen(1, n - 1);
      xs = hv(2, n - 2);
      pulse = 1'b0;
      if (pend.size() > 0 && pend[0] == n) begin
        void'(pend.pop_front());
        if (!det_n) begin
          pulse = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      fire = 1'b0;
      if (div_load) m_period = (int'(div_val) < 2) ? 2 : int'(div_val);
      case (m_mode)
        M_IDLE: begin
          if (rs) begin
            m_mode = M_RUN;
            m_due = n + m_period;
          end else if (bs && !bp) begin
            m_mode = M_STEP;
          end
        end
        M_RUN: begin
          if (!rs) m_mode = M_IDLE;
          else if (div_load) m_due = n + m_period;
          else if (n == m_due) begin
            fire = 1'b1;
            m_due = n + m_period;
          end
        end
        default: begin
          fire = !div_load;
          m_mode = M_IDLE;
        end
      endcase
      m_step = fire;
      if (fire) begin
        m_x = xs;
        m_blink = !m_blink;
        pend.push_back(n + 2);
      end
      m_pulse = pulse;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("step_en", step_en, m_step);
    check("x_out", x_out, m_x);
    check("det_pulse", det_pulse, m_pulse);
    check("blinkled", blinkled, m_blink);
    check("det_cnt", det_cnt, m_cnt);
    check("step_spacing", step_en & prev_step, 0);
    prev_step = step_en;
  endtask

  task automatic wait_step(output int gap, input bit rand_x);
    int i;
    gap = -1;
    i = 0;
    while (gap < 0 && i < 200) begin
      i++;
      if (rand_x) x_in = 1'($urandom_range(0, 1));
      tick();
      if (step_en) gap = i;
    end
    check("step_seen", gap > 0, 1);
  endtask

  initial begin
    int g, steps, pulses, c0, guard, run_hold, btn_left, btn_gap;
    logic [3:0] pat;

    rst_n = 0; run_sw = 0; step_btn = 0; x_in = 0; div_load = 0; div_val = '0; det_n = 1;
    repeat (2) tick();
    check("rst_step_en", step_en, 0);
    check("rst_det_cnt", det_cnt, 0);
    check("rst_blink", blinkled, 0);

    // free run from reset release: latency, then fixed period
    rst_n = 1; run_sw = 1;
    wait_step(g, 1);
    check("first_step_lat", g, SW_LAT + 1 + DIV_DEF);
    for (int i = 0; i < 3; i++) begin
      wait_step(g, 1);
      check("run_period", g, DIV_DEF);
    end

    // 0,0,1,1 delivered over four steps, detection reported after the fourth
    pat = 4'b1100;
    for (int b = 0; b < 4; b++) begin
      x_in = pat[b];
      wait_step(g, 0);
      check("x_out_pattern", x_out, pat[b]);
    end
    c0 = int'(det_cnt);
    pulses = 0;
    x_in = 0;
    det_n = 0;
    tick(); pulses += int'(det_pulse); check("x_out_hold", x_out, 1);
    tick(); pulses += int'(det_pulse); check("x_out_hold", x_out, 1);
    det_n = 1;
    tick(); pulses += int'(det_pulse); check("x_out_hold", x_out, 1);
    tick(); pulses += int'(det_pulse);
    check("detect_count", det_cnt, c0 + 1);
    check("detect_pulses", pulses, 1);

    // single step: one long press gives exactly one step
    run_sw = 0;
    repeat (SW_LAT + 2) tick();
    steps = 0;
    step_btn = 1;
    repeat (HOLD) begin tick(); steps += int'(step_en); end
    step_btn = 0;
    repeat (HOLD + 6) begin tick(); steps += int'(step_en); end
    check("single_step_count", steps, 1);

    // a press while free-running is not remembered after leaving RUN
    run_sw = 1;
    repeat (SW_LAT + 2) tick();
    step_btn = 1;
    repeat (HOLD) tick();
    step_btn = 0;
    repeat (HOLD) tick();
    run_sw = 0;
    repeat (SW_LAT + 2) tick();
    steps = 0;
    repeat (20) begin tick(); steps += int'(step_en); end
    check("press_in_run_ignored", steps, 0);

    // period write of 1 lands on a due step: suppressed, clamped to 2
    run_sw = 1;
    repeat (SW_LAT + 2) tick();
    wait_step(g, 1);
    repeat (DIV_DEF - 1) tick();
    div_load = 1; div_val = DIV_W'(1);
    tick();
    check("load_suppress", step_en, 0);
    div_load = 0;
    tick();
    check("load_next1", step_en, 0);
    tick();
    check("load_next2", step_en, 1);
    wait_step(g, 1);
    check("clamp_gap", g, 2);

    // detection counter saturation
    det_n = 0;
    steps = 0;
    guard = 0;
    while (steps < 300 && guard < 3000) begin
      guard++;
      x_in = 1'($urandom_range(0, 1));
      tick();
      steps += int'(step_en);
    end
    det_n = 1;
    repeat (3) tick();
    check("sat_steps", steps, 300);
    check("sat_cnt", det_cnt, CNT_MAX);

    // random mix of mode changes, presses, period writes and detections
    run_hold = 0; btn_left = 0; btn_gap = 0;
    repeat (1500) begin
      x_in  = 1'($urandom_range(0, 1));
      det_n = ($urandom_range(0, 3) != 0);
      run_hold++;
      if (run_hold > 2 * HOLD && $urandom_range(0, 39) == 0) begin
        run_sw = !run_sw;
        run_hold = 0;
      end
      if (btn_left > 0) begin
        btn_left--;
        if (btn_left == 0) begin step_btn = 0; btn_gap = HOLD; end
      end else if (btn_gap > 0) begin
        btn_gap--;
      end else if ($urandom_range(0, 29) == 0) begin
        step_btn = 1;
        btn_left = HOLD;
      end
      div_load = ($urandom_range(0, 49) == 0);
      div_val  = DIV_W'($urandom_range(0, 9));
      tick();
    end
    div_load = 0; step_btn = 0; det_n = 1;

    // one-cycle reset right after a step aborts its pending detection
    run_sw = 1;
    repeat (2 * HOLD + SW_LAT) tick();
    wait_step(g, 1);
    det_n = 0;
    rst_n = 0;
    tick();
    check("midrst_step_en", step_en, 0);
    check("midrst_x_out", x_out, 0);
    check("midrst_det_cnt", det_cnt, 0);
    check("midrst_det_pulse", det_pulse, 0);
    check("midrst_blink", blinkled, 0);
    rst_n = 1;
    wait_step(g, 1);
    det_n = 1;
    check("restart_lat", g, SW_LAT + 1 + DIV_DEF);
    check("restart_det_cnt", det_cnt, 0);

`ifdef SEQ_STEP_DEBOUNCE_EN
    // short bounce on the button never reaches the scheduler
    run_sw = 0;
    repeat (SW_LAT + 4) tick();
    step_btn = 1;
    repeat (3) tick();
    step_btn = 0;
    steps = 0;
    repeat (DBNC + 10) begin tick(); steps += int'(step_en); end
    check("glitch_no_step", steps, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
